// File: rtl/rggen_counter_event_arbiter.sv
// Round-robin merger of per-source up/down event pulses into one counter's single-lane up/down/clear ports.
// Optional sticky saturation flags: define RGGEN_COUNTER_EVENT_ARBITER_OVERFLOW_FLAG_EN.
module rggen_counter_event_arbiter #(
  parameter int REQUESTERS    = 4,
  parameter int PENDING_WIDTH = 4
)(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_hold,
  input  logic [REQUESTERS-1:0] i_up,
  input  logic [REQUESTERS-1:0] i_down,
  input  logic [REQUESTERS-1:0] i_overflow_clear,
  output logic                  o_up,
  output logic                  o_down,
  output logic                  o_clear,
  output logic [REQUESTERS-1:0] o_grant,
  output logic                  o_busy,
  output logic [REQUESTERS-1:0] o_overflow
);
  localparam int IDX_WIDTH = $clog2(REQUESTERS);
  localparam logic signed [PENDING_WIDTH:0] PMAX = (PENDING_WIDTH+1)'((1 << (PENDING_WIDTH-1)) - 1);
  localparam logic signed [PENDING_WIDTH:0] NMAX = -PMAX;
  localparam logic [IDX_WIDTH-1:0] LAST_INIT = IDX_WIDTH'(REQUESTERS-1);

  // Signed unit step: +1 for pos only, -1 for neg only, 0 otherwise.
  function automatic logic signed [PENDING_WIDTH:0] unit_step(input logic pos, input logic neg);
    logic signed [PENDING_WIDTH:0] res;
    case ({pos, neg})
      2'b10:   res = (PENDING_WIDTH+1)'(1);
      2'b01:   res = -(PENDING_WIDTH+1)'(1);
      default: res = '0;
    endcase
    return res;
  endfunction

  logic signed [PENDING_WIDTH-1:0] pending_r     [REQUESTERS];
  logic signed [PENDING_WIDTH-1:0] pending_nxt_s [REQUESTERS];
  logic signed [PENDING_WIDTH:0]   raw_s         [REQUESTERS];
  logic [REQUESTERS-1:0] sat_s;
  logic [REQUESTERS-1:0] nonzero_s;
  logic [REQUESTERS-1:0] sel_onehot_s;
  logic [IDX_WIDTH-1:0]  last_r;
  logic [IDX_WIDTH-1:0]  cand_s;
  logic [IDX_WIDTH-1:0]  sel_idx_s;
  logic                  sel_valid_s;
  logic                  sel_up_s;
  logic                  up_r;
  logic                  down_r;
  logic                  clear_r;
  logic                  busy_r;
  logic [REQUESTERS-1:0] grant_r;

  // Round-robin search starting just after the last issued source.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_idx_s   = '0;
    cand_s      = '0;
    if (!i_hold && !i_clear) begin
      for (int k = 1; k <= REQUESTERS; k++) begin
        cand_s = IDX_WIDTH'((int'(last_r) + k) % REQUESTERS);
        if (!sel_valid_s && (pending_r[cand_s] != '0)) begin
          sel_valid_s = 1'b1;
          sel_idx_s   = cand_s;
        end else begin
          sel_idx_s   = sel_idx_s;
        end
      end
    end else begin
      sel_valid_s = 1'b0;
      sel_idx_s   = '0;
    end
  end

  // Issue direction follows the sign of the selected pending value.
  always_comb begin
    sel_up_s = ~pending_r[sel_idx_s][PENDING_WIDTH-1];
    for (int i = 0; i < REQUESTERS; i++) begin
      sel_onehot_s[i] = sel_valid_s && (sel_idx_s == IDX_WIDTH'(i));
    end
  end

  // Pending update: new event and issued unit applied together, then clamped to +/-PMAX.
  always_comb begin
    for (int i = 0; i < REQUESTERS; i++) begin
      raw_s[i] = $signed({pending_r[i][PENDING_WIDTH-1], pending_r[i]})
               + unit_step(i_up[i], i_down[i])
               - unit_step(sel_onehot_s[i] & sel_up_s, sel_onehot_s[i] & ~sel_up_s);
      if (i_clear) begin
        pending_nxt_s[i] = '0;
        sat_s[i]         = 1'b0;
      end else if (raw_s[i] > PMAX) begin
        pending_nxt_s[i] = PMAX[PENDING_WIDTH-1:0];
        sat_s[i]         = 1'b1;
      end else if (raw_s[i] < NMAX) begin
        pending_nxt_s[i] = NMAX[PENDING_WIDTH-1:0];
        sat_s[i]         = 1'b1;
      end else begin
        pending_nxt_s[i] = raw_s[i][PENDING_WIDTH-1:0];
        sat_s[i]         = 1'b0;
      end
      nonzero_s[i] = (pending_nxt_s[i] != '0);
    end
  end

  // Pending accumulators and round-robin pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REQUESTERS; i++) begin
        pending_r[i] <= '0;
      end
      last_r <= LAST_INIT;
    end else begin
      for (int i = 0; i < REQUESTERS; i++) begin
        pending_r[i] <= pending_nxt_s[i];
      end
      if (i_clear) begin
        last_r <= LAST_INIT;
      end else if (sel_valid_s) begin
        last_r <= sel_idx_s;
      end else begin
        last_r <= last_r;
      end
    end
  end

  // Registered counter-side outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      up_r    <= 1'b0;
      down_r  <= 1'b0;
      clear_r <= 1'b0;
      busy_r  <= 1'b0;
      grant_r <= '0;
    end else begin
      up_r    <= sel_valid_s & sel_up_s;
      down_r  <= sel_valid_s & ~sel_up_s;
      clear_r <= i_clear;
      busy_r  <= |nonzero_s;
      grant_r <= sel_onehot_s;
    end
  end

  assign o_up    = up_r;
  assign o_down  = down_r;
  assign o_clear = clear_r;
  assign o_busy  = busy_r;
  assign o_grant = grant_r;

`ifdef RGGEN_COUNTER_EVENT_ARBITER_OVERFLOW_FLAG_EN
  logic [REQUESTERS-1:0] overflow_r;

  // Sticky saturation flags; a new saturation beats a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overflow_r <= '0;
    end else begin
      overflow_r <= (overflow_r & ~i_overflow_clear) | sat_s;
    end
  end

  assign o_overflow = overflow_r;
`else
  logic unused_overflow_s;
  assign unused_overflow_s = ^{i_overflow_clear, sat_s};
  assign o_overflow        = '0;
`endif

endmodule

// File: tb/tb_rggen_counter_event_arbiter.sv
// Directed self-checking bench for rggen_counter_event_arbiter (REQUESTERS=4, PENDING_WIDTH=4).
module tb_rggen_counter_event_arbiter;
  localparam int R = 4;
`ifdef RGGEN_COUNTER_EVENT_ARBITER_OVERFLOW_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         i_clk;
  logic         i_rst_n;
  logic         i_clear;
  logic         i_hold;
  logic [R-1:0] i_up;
  logic [R-1:0] i_down;
  logic [R-1:0] i_overflow_clear;
  logic         o_up;
  logic         o_down;
  logic         o_clear;
  logic [R-1:0] o_grant;
  logic         o_busy;
  logic [R-1:0] o_overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rggen_counter_event_arbiter #(.REQUESTERS(R), .PENDING_WIDTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_hold(i_hold),
    .i_up(i_up), .i_down(i_down), .i_overflow_clear(i_overflow_clear),
    .o_up(o_up), .o_down(o_down), .o_clear(o_clear), .o_grant(o_grant),
    .o_busy(o_busy), .o_overflow(o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_clear = 1'b0;
    i_hold  = 1'b0;
    i_up    = '0;
    i_down  = '0;
    i_overflow_clear = '0;
    #13;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({o_up, o_down, o_clear, o_busy} !== 4'b0000) $display("FAIL reset_ctrl got %b exp 0000", {o_up, o_down, o_clear, o_busy});
    else pass_cnt++;
    total_cnt++;
    if (o_grant !== 4'b0000) $display("FAIL reset_grant got %b exp 0000", o_grant);
    else pass_cnt++;
    total_cnt++;
    if (o_overflow !== 4'b0000) $display("FAIL reset_overflow got %b exp 0000", o_overflow);
    else pass_cnt++;
  endtask

  task automatic test_single();
    logic exp_up;
    logic exp_busy;
    int net = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      exp_up   = (c >= 2 && c <= 4);
      exp_busy = (c >= 1 && c <= 3);
      total_cnt++;
      if (o_up !== exp_up || o_down !== 1'b0) $display("FAIL single_updown c=%0d got %b%b exp %b0", c, o_up, o_down, exp_up);
      else pass_cnt++;
      total_cnt++;
      if (o_grant !== (exp_up ? 4'b0001 : 4'b0000)) $display("FAIL single_grant c=%0d got %b", c, o_grant);
      else pass_cnt++;
      total_cnt++;
      if (o_busy !== exp_busy) $display("FAIL single_busy c=%0d got %b exp %b", c, o_busy, exp_busy);
      else pass_cnt++;
      net += int'(o_up) - int'(o_down);
      i_up = (c < 3) ? 4'b0001 : 4'b0000;
      step();
    end
    total_cnt++;
    if (net !== 3) $display("FAIL single_net got %0d exp 3", net);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [R-1:0] exp_grant;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      exp_grant = (c >= 2 && c <= 5) ? (4'b0001 << (c - 2)) : 4'b0000;
      total_cnt++;
      if (o_grant !== exp_grant || o_up !== (exp_grant != 4'b0000)) $display("FAIL contention c=%0d got grant %b up %b exp grant %b", c, o_grant, o_up, exp_grant);
      else pass_cnt++;
      i_up = (c == 0) ? 4'b1111 : 4'b0000;
      step();
    end
  endtask

  task automatic test_mixed();
    logic exp_up;
    logic exp_down;
    logic [R-1:0] exp_grant;
    int net = 0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      exp_down  = (c >= 2 && c <= 4);
      exp_up    = (c == 5 || c == 6);
      exp_grant = exp_down ? 4'b0010 : (exp_up ? 4'b0100 : 4'b0000);
      total_cnt++;
      if (o_up !== exp_up || o_down !== exp_down || o_grant !== exp_grant)
        $display("FAIL mixed c=%0d got up %b down %b grant %b exp up %b down %b grant %b", c, o_up, o_down, o_grant, exp_up, exp_down, exp_grant);
      else pass_cnt++;
      net += int'(o_up) - int'(o_down);
      i_down = (c < 3) ? 4'b0010 : 4'b0000;
      i_up   = (c == 3 || c == 4) ? 4'b0100 : 4'b0000;
      step();
    end
    total_cnt++;
    if (net !== -1) $display("FAIL mixed_net got %0d exp -1", net);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic [R-1:0] exp_ovf;
    int ups = 0;
    do_reset();
    i_hold = 1'b1;
    for (int c = 0; c < 9; c++) begin
      exp_ovf = (OVF_EN && c >= 8) ? 4'b0001 : 4'b0000;
      total_cnt++;
      if (o_up !== 1'b0 || o_overflow !== exp_ovf) $display("FAIL sat_hold c=%0d got up %b ovf %b exp up 0 ovf %b", c, o_up, o_overflow, exp_ovf);
      else pass_cnt++;
      i_up = 4'b0001;
      step();
    end
    i_up   = 4'b0000;
    i_hold = 1'b0;
    for (int c = 0; c < 12; c++) begin
      ups += int'(o_up);
      step();
    end
    exp_ovf = OVF_EN ? 4'b0001 : 4'b0000;
    total_cnt++;
    if (ups !== 7) $display("FAIL sat_drain got %0d ups exp 7", ups);
    else pass_cnt++;
    total_cnt++;
    if (o_busy !== 1'b0) $display("FAIL sat_busy got %b exp 0", o_busy);
    else pass_cnt++;
    total_cnt++;
    if (o_overflow !== exp_ovf) $display("FAIL sat_sticky got %b exp %b", o_overflow, exp_ovf);
    else pass_cnt++;
    i_overflow_clear = 4'b0001;
    step();
    i_overflow_clear = 4'b0000;
    total_cnt++;
    if (o_overflow !== 4'b0000) $display("FAIL sat_flag_clear got %b exp 0000", o_overflow);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    logic exp_up;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      exp_up = (c == 5 || c == 6);
      total_cnt++;
      if (o_up !== exp_up) $display("FAIL hold c=%0d got %b exp %b", c, o_up, exp_up);
      else pass_cnt++;
      i_up   = (c <= 1) ? 4'b0001 : 4'b0000;
      i_hold = (c >= 1 && c <= 3);
      step();
    end
  endtask

  task automatic test_clear();
    logic [R-1:0] exp_ovf;
    int ups = 0;
    do_reset();
    exp_ovf = OVF_EN ? 4'b1000 : 4'b0000;
    i_hold = 1'b1;
    for (int c = 0; c < 8; c++) begin
      i_up = (c < 5) ? 4'b1100 : 4'b1000;
      step();
    end
    total_cnt++;
    if (o_overflow !== exp_ovf || o_busy !== 1'b1) $display("FAIL clear_pre got ovf %b busy %b exp ovf %b busy 1", o_overflow, o_busy, exp_ovf);
    else pass_cnt++;
    i_hold  = 1'b0;
    i_clear = 1'b1;
    i_up    = 4'b0100;
    step();
    i_clear = 1'b0;
    i_up    = 4'b0000;
    total_cnt++;
    if (o_clear !== 1'b1 || o_up !== 1'b0 || o_down !== 1'b0 || o_grant !== 4'b0000)
      $display("FAIL clear_pulse got clr %b up %b down %b grant %b exp 1 0 0 0000", o_clear, o_up, o_down, o_grant);
    else pass_cnt++;
    total_cnt++;
    if (o_busy !== 1'b0) $display("FAIL clear_busy got %b exp 0", o_busy);
    else pass_cnt++;
    total_cnt++;
    if (o_overflow !== exp_ovf) $display("FAIL clear_ovf got %b exp %b", o_overflow, exp_ovf);
    else pass_cnt++;
    step();
    total_cnt++;
    if (o_clear !== 1'b0) $display("FAIL clear_single got %b exp 0", o_clear);
    else pass_cnt++;
    for (int c = 0; c < 6; c++) begin
      ups += int'(o_up) + int'(o_down);
      step();
    end
    total_cnt++;
    if (ups !== 0) $display("FAIL clear_drain got %0d issues exp 0", ups);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    i_up = 4'b1111;
    step();
    i_up = 4'b0000;
    step();
    step();
    total_cnt++;
    if (o_grant !== 4'b0010) $display("FAIL arst_pre got %b exp 0010", o_grant);
    else pass_cnt++;
    #3;
    i_rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({o_up, o_down, o_busy, o_grant} !== 7'b0000000) $display("FAIL arst_immediate got %b exp 0000000", {o_up, o_down, o_busy, o_grant});
    else pass_cnt++;
    #10;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step();
    total_cnt++;
    if ({o_up, o_busy, o_grant} !== 6'b000000) $display("FAIL arst_no_partial got %b exp 000000", {o_up, o_busy, o_grant});
    else pass_cnt++;
    i_up = 4'b1001;
    step();
    i_up = 4'b0000;
    step();
    total_cnt++;
    if (o_grant !== 4'b0001) $display("FAIL arst_ptr_first got %b exp 0001", o_grant);
    else pass_cnt++;
    step();
    total_cnt++;
    if (o_grant !== 4'b1000) $display("FAIL arst_ptr_second got %b exp 1000", o_grant);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_mixed();
    test_saturation();
    test_hold();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rggen_counter_event_arbiter.md
# rggen_counter_event_arbiter

Merges up/down event pulses from REQUESTERS independent sources into the single-lane up/down ports of one counter bit field (UP_WIDTH = DOWN_WIDTH = 1). Each source has a saturating signed pending accumulator. A round-robin scheduler drains one unit per cycle into the counter. The block sits between hardware event producers and the counter's i_up/i_down/i_clear ports. It also suspends draining while software writes the counter.

## Interface
- REQUESTERS, 4: number of event sources, at least 2.
- PENDING_WIDTH, 4: signed pending-accumulator width, at least 2. Range is ±PMAX, PMAX = 2^(PENDING_WIDTH-1)-1.
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_clear  input  1  flush all pending events and clear the counter.
- i_hold  input  1  suspend issue; driven from the counter's i_sw_write_valid.
- i_up  input  REQUESTERS  per-source increment pulse.
- i_down  input  REQUESTERS  per-source decrement pulse.
- i_overflow_clear  input  REQUESTERS  per-source sticky-flag clear.
- o_up  output  1  registered increment to the counter i_up.
- o_down  output  1  registered decrement to the counter i_down.
- o_clear  output  1  registered clear to the counter i_clear.
- o_grant  output  REQUESTERS  registered one-hot marker of the source issued this cycle.
- o_busy  output  1  registered; 1 when any pending value is nonzero.
- o_overflow  output  REQUESTERS  sticky saturation flags.

## Operation
- Reset values: all pending = 0; pointer last = REQUESTERS-1; o_up, o_down, o_clear, o_grant, o_busy, o_overflow all 0.
- Per-source net input each cycle: d_in = i_up[i] - i_down[i]. The value is +1, -1 or 0; both pulses asserted together gives 0.
- Selection is combinational and uses current pending values.
  - It applies only when i_hold = 0 and i_clear = 0.
  - Search starts at last+1 mod REQUESTERS and picks the first source with pending != 0.
  - If no source qualifies, there is no selection.
- Issue direction: d_iss = +1 when the selected pending > 0, and -1 when it is < 0.
  - Registered outputs: o_up = (d_iss = +1), o_down = (d_iss = -1), o_grant = one-hot of the selected source.
  - On an issue, last takes the selected index.
- Pending update for each source: raw = pending + d_in - (selected ? d_iss : 0), computed at PENDING_WIDTH+1 bits.
  - If raw > PMAX, pending = PMAX and overflow is flagged.
  - If raw < -PMAX, pending = -PMAX and overflow is flagged.
  - Otherwise pending = raw.
- Simultaneous event and issue on the same source are both applied in the same cycle; no event is lost.
- Clear: when i_clear = 1 in cycle t, at the edge ending t:
  - all pending values become 0, last = REQUESTERS-1, and any i_up/i_down pulses in cycle t are discarded;
  - in cycle t+1, o_clear = 1 and o_up = o_down = 0;
  - o_overflow is not affected.
- Hold: i_hold = 1 stops selection only. Pending values keep accumulating and saturating.
- o_busy is registered from the post-update pending values: OR over sources of (next pending != 0).
- o_overflow[i]:
  - it is set on any saturation event of source i;
  - it is cleared by i_overflow_clear[i];
  - if set and clear occur in the same cycle, set wins.

## Timing
- Event pulse in cycle t: pending is updated at edge t. The earliest o_up/o_down is in cycle t+2, which is 2-cycle latency.
- Issue throughput is one unit per cycle, shared round-robin.
  - Worst-case wait for a source with nonzero pending is REQUESTERS-1 cycles after it becomes eligible.
- i_hold asserted in cycle t gives o_up = o_down = 0 in cycle t+1.
  - The software write lands in the counter in cycle t, before any later issue.
- o_clear is a single-cycle pulse for each cycle i_clear is high, delayed by one cycle.
- Reset is asynchronous and may occur mid-drain. All state returns to reset values immediately and no partial issue remains.

## Configuration
- RGGEN_COUNTER_EVENT_ARBITER_OVERFLOW_FLAG_EN
  - Defined: sticky o_overflow flags and the i_overflow_clear handling are implemented as above.
  - Undefined: no flag registers. o_overflow is tied to 0 and i_overflow_clear is ignored. Saturation clamping is unchanged.

## Test plan
- Single source: i_up[0] pulses in cycles 0, 1, 2.
  - Expected: o_up = 1 with o_grant = 4'b0001 in cycles 2, 3, 4; o_busy falls after cycle 3; the counter ends at +3.
- Contention: i_up[3:0] = 4'b1111 for one cycle from reset.
  - Expected: grants in order 0001, 0010, 0100, 1000 over 4 consecutive cycles, starting 2 cycles after the pulse.
- Mixed direction: source 1 gets 3 downs, then source 2 gets 2 ups.
  - Expected: o_down issued 3 times and o_up 2 times, interleaved round-robin; net counter change is -1.
- Saturation, PENDING_WIDTH = 4: i_hold = 1 while source 0 receives 9 up pulses.
  - Expected: pending clamps at 7 and o_overflow[0] = 1.
  - Release hold: exactly 7 o_up pulses follow. Then i_overflow_clear[0] drops the flag.
- Hold: i_hold = 1 for 3 cycles with pending = 2.
  - Expected: no o_up during the hold window (offset by 1 cycle); 2 issues resume after release.
- Clear mid-drain: pending = 5 on source 2, assert i_clear together with an i_up[2] pulse.
  - Expected: o_clear = 1 in the next cycle, no further o_up, o_busy = 0, o_overflow unchanged.
